busca_binaria: RTL and testbench

Successive-approximation search engine that recovers an unknown N-bit value using only magnitude-comparator flags. It drives a trial operand into an external `comparador_85` instance, with the trial on A and the unknown on B. Each cycle it consumes that comparator's ALB/AGB/AEB outputs and converges MSB-first in at most N trials. It is used in the game datapath to locate a target value, such as a screen coordinate, against a comparator whose B input holds the value.

---
 rtl/busca_binaria.sv | 115 +++++++++++
 tb/tb_busca_binaria.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/busca_binaria.sv
// Successive-approximation search: recovers an unknown N-bit value MSB-first
// from the ALB/AGB/AEB flags of an external comparator fed with our trial.
module busca_binaria #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         iniciar,
  input  logic         ALB,
  input  logic         AGB,
  input  logic         AEB,
  output logic [N-1:0] tentativa,
  output logic [N-1:0] valor,
  output logic [N-1:0] tentativas,
  output logic         pronto,
  output logic         erro
);

  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0]  ONE   = 1;
  localparam logic [KW-1:0] K_ONE = 1;
  localparam logic [KW-1:0] K_MSB = KW'(N - 1);

  typedef enum logic [1:0] {OCIOSO, BUSCA, FIM} estado_t;

  estado_t       estado, estado_n;
  logic [N-1:0]  r, r_n;
  logic [KW-1:0] k, k_n;
  logic [N-1:0]  valor_n, cnt_n, tentativa_n, t;
  logic          erro_n;

  function automatic logic [N-1:0] trial(input logic [N-1:0] pre,
                                         input logic [KW-1:0] idx);
    return pre | (ONE << idx);
  endfunction

  assign t      = trial(r, k);
  assign pronto = (estado == FIM);

  always_comb begin
    estado_n = estado;
    r_n      = r;
    k_n      = k;
    valor_n  = valor;
    cnt_n    = tentativas;
    erro_n   = erro;
    case (estado)
      OCIOSO, FIM: begin
        if (iniciar) begin
          r_n      = '0;
          k_n      = K_MSB;
          cnt_n    = '0;
          erro_n   = 1'b0;
          valor_n  = '0;
          estado_n = BUSCA;
        end
      end
      BUSCA: begin
        cnt_n = tentativas + ONE;
        case ({ALB, AGB, AEB})
          3'b001: begin
            valor_n  = t;
            estado_n = FIM;
          end
          3'b100: begin
            r_n = t;
            if (k == '0) begin
              valor_n  = t;
              estado_n = FIM;
            end else begin
              k_n = k - K_ONE;
            end
          end
          3'b010: begin
            if (k == '0) begin
              valor_n  = r;
              estado_n = FIM;
            end else begin
              k_n = k - K_ONE;
            end
          end
          default: begin
            // Comparator flags not one-hot: stop and report the accepted prefix
            erro_n   = 1'b1;
            valor_n  = r;
            estado_n = FIM;
          end
        endcase
      end
      default: estado_n = OCIOSO;
    endcase
    tentativa_n = (estado_n == BUSCA) ? trial(r_n, k_n) : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado     <= OCIOSO;
      r          <= '0;
      k          <= '0;
      tentativa  <= '0;
      valor      <= '0;
      tentativas <= '0;
      erro       <= 1'b0;
    end else begin
      estado     <= estado_n;
      r          <= r_n;
      k          <= k_n;
      tentativa  <= tentativa_n;
      valor      <= valor_n;
      tentativas <= cnt_n;
      erro       <= erro_n;
    end
  end

endmodule

// File: tb/tb_busca_binaria.sv
// Directed bench for busca_binaria (N=4) with a behavioural comparator model.
module tb_busca_binaria;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic       ALB, AGB, AEB;
  logic [3:0] tentativa, valor, tentativas;
  logic       pronto, erro;

  logic [3:0] unknown;
  logic       force_bad;
  int         compared = 0;
  int         mismatched = 0;

  busca_binaria #(.N(4)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .ALB(ALB), .AGB(AGB), .AEB(AEB),
    .tentativa(tentativa), .valor(valor), .tentativas(tentativas),
    .pronto(pronto), .erro(erro)
  );

  always #5 clock = ~clock;

  // Comparator with A=tentativa, B=unknown, cascade inputs ALBi=0 AGBi=0 AEBi=1
  always_comb begin
    if (force_bad) begin
      {ALB, AGB, AEB} = 3'b000;
    end else begin
      ALB = (tentativa < unknown);
      AGB = (tentativa > unknown);
      AEB = (tentativa == unknown);
    end
  end

  task automatic start();
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
  endtask

  task automatic test_reset();
    compared++;
    if ({tentativa, valor, tentativas, pronto, erro} !== 14'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h required 0", {tentativa, valor, tentativas, pronto, erro});
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    compared++;
    if (tentativa !== 4'd0 || pronto !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_after_reset: tentativa=%0d pronto=%0b required 0/0", tentativa, pronto);
    end
  endtask

  task automatic test_five();
    logic [3:0] exp [4] = '{4'd8, 4'd4, 4'd6, 4'd5};
    unknown = 4'd5;
    start();
    for (int j = 0; j < 4; j++) begin
      compared++;
      if (tentativa !== exp[j] || pronto !== 1'b0) begin
        mismatched++;
        $display("FAIL five_trial%0d: tentativa=%0d pronto=%0b required %0d/0", j + 1, tentativa, pronto, exp[j]);
      end
      @(negedge clock);
    end
    compared++;
    if (pronto !== 1'b1 || valor !== 4'd5 || tentativas !== 4'd4 || erro !== 1'b0 || tentativa !== 4'd0) begin
      mismatched++;
      $display("FAIL five_result: pronto=%0b valor=%0d tentativas=%0d erro=%0b tentativa=%0d required 1/5/4/0/0",
               pronto, valor, tentativas, erro, tentativa);
    end
  endtask

  task automatic test_early_exit();
    unknown = 4'd8;
    start();
    compared++;
    if (tentativa !== 4'd8 || pronto !== 1'b0) begin
      mismatched++;
      $display("FAIL eight_trial1: tentativa=%0d pronto=%0b required 8/0", tentativa, pronto);
    end
    @(negedge clock);
    compared++;
    if (pronto !== 1'b1 || valor !== 4'd8 || tentativas !== 4'd1 || erro !== 1'b0) begin
      mismatched++;
      $display("FAIL eight_result: pronto=%0b valor=%0d tentativas=%0d erro=%0b required 1/8/1/0",
               pronto, valor, tentativas, erro);
    end
  endtask

  task automatic test_zero();
    logic [3:0] exp [4] = '{4'd8, 4'd4, 4'd2, 4'd1};
    unknown = 4'd0;
    start();
    for (int j = 0; j < 4; j++) begin
      compared++;
      if (tentativa !== exp[j]) begin
        mismatched++;
        $display("FAIL zero_trial%0d: tentativa=%0d required %0d", j + 1, tentativa, exp[j]);
      end
      @(negedge clock);
    end
    compared++;
    if (pronto !== 1'b1 || valor !== 4'd0 || tentativas !== 4'd4 || erro !== 1'b0) begin
      mismatched++;
      $display("FAIL zero_result: pronto=%0b valor=%0d tentativas=%0d erro=%0b required 1/0/4/0",
               pronto, valor, tentativas, erro);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_a [4] = '{4'd8, 4'd12, 4'd14, 4'd15};
    logic [3:0] exp_b [4] = '{4'd8, 4'd4, 4'd2, 4'd3};
    unknown = 4'd15;
    start();
    for (int j = 0; j < 4; j++) begin
      compared++;
      if (tentativa !== exp_a[j]) begin
        mismatched++;
        $display("FAIL fifteen_trial%0d: tentativa=%0d required %0d", j + 1, tentativa, exp_a[j]);
      end
      @(negedge clock);
    end
    compared++;
    if (pronto !== 1'b1 || valor !== 4'd15 || tentativas !== 4'd4) begin
      mismatched++;
      $display("FAIL fifteen_result: pronto=%0b valor=%0d tentativas=%0d required 1/15/4", pronto, valor, tentativas);
    end
    unknown = 4'd3;
    start();
    for (int j = 0; j < 4; j++) begin
      compared++;
      if (tentativa !== exp_b[j] || pronto !== 1'b0) begin
        mismatched++;
        $display("FAIL three_trial%0d: tentativa=%0d pronto=%0b required %0d/0", j + 1, tentativa, pronto, exp_b[j]);
      end
      @(negedge clock);
    end
    compared++;
    if (pronto !== 1'b1 || valor !== 4'd3 || tentativas !== 4'd4 || erro !== 1'b0) begin
      mismatched++;
      $display("FAIL three_result: pronto=%0b valor=%0d tentativas=%0d erro=%0b required 1/3/4/0",
               pronto, valor, tentativas, erro);
    end
  endtask

  task automatic test_bad_flags();
    unknown = 4'd12;
    start();
    compared++;
    if (tentativa !== 4'd8) begin
      mismatched++;
      $display("FAIL bad_trial1: tentativa=%0d required 8", tentativa);
    end
    @(negedge clock);
    force_bad = 1'b1;
    compared++;
    if (tentativa !== 4'd12) begin
      mismatched++;
      $display("FAIL bad_trial2: tentativa=%0d required 12", tentativa);
    end
    @(negedge clock);
    force_bad = 1'b0;
    compared++;
    if (erro !== 1'b1 || pronto !== 1'b1 || tentativas !== 4'd2 || valor !== 4'd8) begin
      mismatched++;
      $display("FAIL bad_result: erro=%0b pronto=%0b tentativas=%0d valor=%0d required 1/1/2/8",
               erro, pronto, tentativas, valor);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] exp [4] = '{4'd8, 4'd4, 4'd6, 4'd5};
    unknown = 4'd5;
    start();
    for (int j = 0; j < 3; j++) begin
      compared++;
      if (tentativa !== exp[j]) begin
        mismatched++;
        $display("FAIL abort_trial%0d: tentativa=%0d required %0d", j + 1, tentativa, exp[j]);
      end
      if (j < 2) @(negedge clock);
    end
    #2 reset = 1'b1;
    #1;
    compared++;
    if ({tentativa, valor, tentativas, pronto, erro} !== 14'd0) begin
      mismatched++;
      $display("FAIL async_reset: got %h required 0", {tentativa, valor, tentativas, pronto, erro});
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    compared++;
    if (tentativa !== 4'd0 || pronto !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_after_abort: tentativa=%0d pronto=%0b required 0/0", tentativa, pronto);
    end
    start();
    for (int j = 0; j < 4; j++) begin
      iniciar = (j == 1);
      compared++;
      if (tentativa !== exp[j] || pronto !== 1'b0) begin
        mismatched++;
        $display("FAIL rerun_trial%0d: tentativa=%0d pronto=%0b required %0d/0", j + 1, tentativa, pronto, exp[j]);
      end
      @(negedge clock);
    end
    iniciar = 1'b0;
    compared++;
    if (pronto !== 1'b1 || valor !== 4'd5 || tentativas !== 4'd4 || erro !== 1'b0) begin
      mismatched++;
      $display("FAIL rerun_result: pronto=%0b valor=%0d tentativas=%0d erro=%0b required 1/5/4/0",
               pronto, valor, tentativas, erro);
    end
  endtask

  initial begin
    reset     = 1'b1;
    iniciar   = 1'b0;
    unknown   = 4'd0;
    force_bad = 1'b0;
    @(negedge clock);
    test_reset();
    test_five();
    test_early_exit();
    test_zero();
    test_back_to_back();
    test_bad_flags();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
